// File: rtl/core_db_ecc_pkg.sv
// rtl/core_db_ecc_pkg.sv - shared width helpers for the data-bucket ECC core
package core_db_ecc_pkg;

    // Hamming parity count: smallest p with 2^p >= data_w + p + 1
    function automatic int calc_p(input int data_w);
        int p;
        p = 1;
        while ((1 << p) < data_w + p + 1) p++;
        return p;
    endfunction

    function automatic logic is_pow2(input int pos);
        return (pos > 0) && ((pos & (pos - 1)) == 0);
    endfunction

    function automatic int pkt_w(input int addr_w, input int data_w, input int secded);
        return addr_w + data_w + calc_p(data_w) + secded;
    endfunction

    function automatic int out_w(input int addr_w, input int data_w);
        return addr_w + data_w;
    endfunction

endpackage

// File: rtl/db_sync_fifo.sv
// rtl/db_sync_fifo.sv - synchronous FIFO with zeroed head when empty
module db_sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4,
    localparam int AW = $clog2(DEPTH),
    localparam int CW = AW + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic             head_valid,
    output logic [WIDTH-1:0] head_data,
    output logic [CW-1:0]    count
);
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             do_push, do_pop;

    always_comb begin
        do_pop   = pop && (count_q != '0);
        do_push  = push && ((count_q != CW'(DEPTH)) || do_pop);
        wr_ptr_d = do_push ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d = do_pop ? rd_ptr_q + 1'b1 : rd_ptr_q;
        count_d  = count_q + CW'(do_push) - CW'(do_pop);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= push_data;
    end

    assign head_valid = (count_q != '0);
    assign head_data  = head_valid ? mem_q[rd_ptr_q] : '0;
    assign count      = count_q;
endmodule

// File: rtl/core_db_ecc.sv
// rtl/core_db_ecc.sv - Hamming/SECDED correcting data-bucket core with output FIFO
module core_db_ecc
    import core_db_ecc_pkg::*;
#(
    parameter int ADDR_W     = 4,
    parameter int DATA_W     = 4,
    parameter int SECDED     = 0,
    parameter int FIFO_DEPTH = 4,
    parameter int CNT_W      = 8,
    localparam int P     = calc_p(DATA_W),
    localparam int N     = DATA_W + P,
    localparam int PKT_W = pkt_w(ADDR_W, DATA_W, SECDED),
    localparam int OUT_W = out_w(ADDR_W, DATA_W)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [PKT_W-1:0] in_pkt,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OUT_W-1:0] out_data,
    output logic             out_corrected,
    output logic             out_uncorr,
    output logic [P-1:0]     out_syndrome,
    input  logic             clr_cnt,
    output logic [CNT_W-1:0] corr_cnt,
    output logic [CNT_W-1:0] uncorr_cnt
);
    typedef struct packed {
        logic         corrected;
        logic         uncorr;
        logic [P-1:0] syndrome;
    } status_t;

    localparam int ENTRY_W = OUT_W + $bits(status_t);
    localparam int FCW     = $clog2(FIFO_DEPTH) + 1;

    logic               s1_valid_q, s1_valid_d;
    logic [PKT_W-1:0]   s1_pkt_q, s1_pkt_d;
    logic [CNT_W-1:0]   corr_cnt_q, corr_cnt_d, uncorr_cnt_q, uncorr_cnt_d;
    logic [N:1]         cw;
    logic [P-1:0]       syn;
    logic               par_bad, flip;
    status_t            st, head_st;
    logic [DATA_W-1:0]  data;
    logic [FCW-1:0]     fifo_count;
    logic [ENTRY_W-1:0] head;

    // Space is reserved for the word sitting in S1, so a push can never overflow.
    assign in_ready = rst_n && ((fifo_count + FCW'(s1_valid_q)) < FCW'(FIFO_DEPTH));

    always_comb begin
        s1_valid_d = in_valid && in_ready;
        s1_pkt_d   = s1_valid_d ? in_pkt : s1_pkt_q;
    end

    always_comb begin
        cw  = s1_pkt_q[ADDR_W +: N];
        syn = '0;
        for (int j = 0; j < P; j++) begin
            for (int i = 1; i <= N; i++) begin
                if (((i >> j) & 1) == 1) syn[j] = syn[j] ^ cw[i];
            end
        end
        par_bad = ^cw;
        if (SECDED != 0) par_bad = par_bad ^ s1_pkt_q[PKT_W-1];

        flip         = 1'b0;
        st.corrected = 1'b0;
        st.uncorr    = 1'b0;
        st.syndrome  = syn;
        if (SECDED == 0) begin
            if (syn != '0) begin
                if (int'(syn) <= N) begin
                    flip         = 1'b1;
                    st.corrected = 1'b1;
                end else begin
                    st.uncorr = 1'b1;
                end
            end
        end else begin
            // Zero syndrome with bad parity means only the overall parity bit flipped.
            if (syn == '0) begin
                st.corrected = par_bad;
            end else if (par_bad && (int'(syn) <= N)) begin
                flip         = 1'b1;
                st.corrected = 1'b1;
            end else begin
                st.uncorr = 1'b1;
            end
        end
    end

    for (genvar g = 1; g <= N; g++) begin : g_data
        if (!is_pow2(g)) begin : g_bit
            assign data[g - $clog2(g + 1) - 1] = cw[g] ^ (flip && (int'(syn) == g));
        end
    end

    always_comb begin
        corr_cnt_d   = corr_cnt_q;
        uncorr_cnt_d = uncorr_cnt_q;
        if (clr_cnt) begin
            corr_cnt_d   = CNT_W'(s1_valid_q && st.corrected);
            uncorr_cnt_d = CNT_W'(s1_valid_q && st.uncorr);
        end else begin
            if (s1_valid_q && st.corrected && (corr_cnt_q != '1)) corr_cnt_d = corr_cnt_q + 1'b1;
            if (s1_valid_q && st.uncorr && (uncorr_cnt_q != '1)) uncorr_cnt_d = uncorr_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1_valid_q   <= 1'b0;
            s1_pkt_q     <= '0;
            corr_cnt_q   <= '0;
            uncorr_cnt_q <= '0;
        end else begin
            s1_valid_q   <= s1_valid_d;
            s1_pkt_q     <= s1_pkt_d;
            corr_cnt_q   <= corr_cnt_d;
            uncorr_cnt_q <= uncorr_cnt_d;
        end
    end

    db_sync_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk        (clk),
        .rst_n      (rst_n),
        .push       (s1_valid_q),
        .push_data  ({data, s1_pkt_q[ADDR_W-1:0], st}),
        .pop        (out_valid && out_ready),
        .head_valid (out_valid),
        .head_data  (head),
        .count      (fifo_count)
    );

    assign {out_data, head_st} = head;
    assign out_corrected = head_st.corrected;
    assign out_uncorr    = head_st.uncorr;
    assign out_syndrome  = head_st.syndrome;
    assign corr_cnt      = corr_cnt_q;
    assign uncorr_cnt    = uncorr_cnt_q;
endmodule

// File: tb/tb_core_db_ecc.sv
// tb/tb_core_db_ecc.sv - self-checking bench for core_db_ecc (Hamming(7,4) and SECDED variants)
module tb_core_db_ecc;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n, out_ready, clr_cnt;
    logic        iv0, iv1;
    logic [10:0] pkt0;
    logic [11:0] pkt1;
    logic        ir0, ov0, oc0, ou0, ir1, ov1, oc1, ou1;
    logic [7:0]  od0, od1, cc0, uc0;
    logic [2:0]  os0, os1;
    logic [1:0]  cc1, uc1;

    core_db_ecc dut0 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv0), .in_ready(ir0), .in_pkt(pkt0),
        .out_valid(ov0), .out_ready(out_ready), .out_data(od0), .out_corrected(oc0),
        .out_uncorr(ou0), .out_syndrome(os0), .clr_cnt(clr_cnt), .corr_cnt(cc0), .uncorr_cnt(uc0)
    );

    core_db_ecc #(.SECDED(1), .CNT_W(2)) dut1 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv1), .in_ready(ir1), .in_pkt(pkt1),
        .out_valid(ov1), .out_ready(out_ready), .out_data(od1), .out_corrected(oc1),
        .out_uncorr(ou1), .out_syndrome(os1), .clr_cnt(clr_cnt), .corr_cnt(cc1), .uncorr_cnt(uc1)
    );

    typedef struct packed {
        logic [7:0] data;
        logic       corr;
        logic       unc;
        logic [2:0] syn;
    } exp_t;

    exp_t q0[$];
    exp_t q1[$];
    exp_t e0, e1;
    int   checks = 0;
    int   errors = 0;
    int   mc0 = 0, mu0 = 0, mc1 = 0, mu1 = 0;
    int   acc;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int sat(input int v, input int m);
        return (v > m) ? m : v;
    endfunction

    // Textbook Hamming encode: data in non-power-of-two slots, parity p covers indices with bit p set
    function automatic logic [7:1] enc(input logic [3:0] d);
        logic [7:1] c;
        int k, pp;
        logic b;
        c = '0;
        k = 0;
        for (int i = 1; i <= 7; i++) begin
            if ((i & (i - 1)) != 0) begin
                c[i] = d[k];
                k++;
            end
        end
        for (int j = 0; j < 3; j++) begin
            pp = 1 << j;
            b  = 1'b0;
            for (int i = 1; i <= 7; i++) if (i != pp && (i & pp) != 0) b = b ^ c[i];
            c[pp] = b;
        end
        return c;
    endfunction

    function automatic logic [3:0] ext(input logic [7:1] c);
        logic [3:0] d;
        int k;
        d = '0;
        k = 0;
        for (int i = 1; i <= 7; i++) begin
            if ((i & (i - 1)) != 0) begin
                d[k] = c[i];
                k++;
            end
        end
        return d;
    endfunction

    task automatic gen0(input int nerr);
        logic [3:0] d, a;
        logic [7:1] c;
        int p;
        d = 4'($urandom);
        a = 4'($urandom);
        c = enc(d);
        p = $urandom_range(1, 7);
        if (nerr != 0) c[p] = ~c[p];
        pkt0 = {c, a};
        e0.data = {d, a};
        e0.corr = (nerr != 0);
        e0.unc  = 1'b0;
        e0.syn  = (nerr != 0) ? 3'(p) : 3'd0;
    endtask

    // Position 8 stands for the overall parity bit; it contributes nothing to the syndrome.
    task automatic gen1(input int nerr);
        logic [3:0] d, a;
        logic [8:1] f;
        int p1, p2;
        logic [2:0] s1, s2;
        d = 4'($urandom);
        a = 4'($urandom);
        f[7:1] = enc(d);
        f[8] = ^f[7:1];
        p1 = $urandom_range(1, 8);
        p2 = p1;
        while (p2 == p1) p2 = $urandom_range(1, 8);
        s1 = (p1 <= 7) ? 3'(p1) : 3'd0;
        s2 = (p2 <= 7) ? 3'(p2) : 3'd0;
        if (nerr >= 1) f[p1] = ~f[p1];
        if (nerr >= 2) f[p2] = ~f[p2];
        pkt1 = {f, a};
        e1.corr = (nerr == 1);
        e1.unc  = (nerr == 2);
        e1.syn  = (nerr == 0) ? 3'd0 : (nerr == 1) ? s1 : (s1 ^ s2);
        e1.data = (nerr == 2) ? {ext(f[7:1]), a} : {d, a};
    endtask

    // Called at a falling edge with inputs applied; scores what the next rising edge will transfer.
    task automatic step();
        exp_t e;
        if (ov0 && out_ready) begin
            chk("dut0 word expected", 32'(q0.size() != 0), 32'd1);
            if (q0.size() != 0) begin
                e = q0.pop_front();
                chk("dut0 word {data,corr,unc,syn}", 32'({od0, oc0, ou0, os0}), 32'(e));
            end
        end
        if (ov1 && out_ready) begin
            chk("dut1 word expected", 32'(q1.size() != 0), 32'd1);
            if (q1.size() != 0) begin
                e = q1.pop_front();
                chk("dut1 word {data,corr,unc,syn}", 32'({od1, oc1, ou1, os1}), 32'(e));
            end
        end
        if (iv0 && ir0) begin
            q0.push_back(e0);
            mc0 = sat(mc0 + int'(e0.corr), 255);
            mu0 = sat(mu0 + int'(e0.unc), 255);
        end
        if (iv1 && ir1) begin
            q1.push_back(e1);
            mc1 = sat(mc1 + int'(e1.corr), 3);
            mu1 = sat(mu1 + int'(e1.unc), 3);
        end
        @(negedge clk);
    endtask

    task automatic drain(input int n);
        iv0 = 1'b0;
        iv1 = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < n; i++) step();
        chk("dut0 queue drained", 32'(q0.size()), 32'd0);
        chk("dut1 queue drained", 32'(q1.size()), 32'd0);
    endtask

    initial begin
        rst_n = 1'b0; iv0 = 1'b0; iv1 = 1'b0; out_ready = 1'b1; clr_cnt = 1'b0;
        pkt0 = '0; pkt1 = '0; e0 = '0; e1 = '0;
        @(negedge clk);
        @(negedge clk);
        chk("reset in_ready", 32'(ir0), 32'd0);
        chk("reset out_valid", 32'(ov0), 32'd0);
        chk("reset head", 32'({od0, oc0, ou0, os0}), 32'd0);
        chk("reset counters", 32'({cc0, uc0, cc1, uc1}), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("in_ready after reset", 32'(ir0), 32'd1);

        // Clean word with two-cycle latency
        pkt0 = 11'h55A; e0 = '{data: 8'hBA, corr: 1'b0, unc: 1'b0, syn: 3'd0}; iv0 = 1'b1;
        step();
        iv0 = 1'b0;
        chk("latency t+1 out_valid", 32'(ov0), 32'd0);
        step();
        chk("latency t+2 out_valid", 32'(ov0), 32'd1);
        step();
        chk("clean corr_cnt", 32'(cc0), 32'd0);

        // Every single-bit position corrects back to data B
        for (int p = 1; p <= 7; p++) begin
            pkt0 = 11'h55A ^ (11'd1 << (3 + p));
            e0 = '{data: 8'hBA, corr: 1'b1, unc: 1'b0, syn: 3'(p)};
            iv0 = 1'b1;
            step();
        end
        drain(6);
        chk("corr_cnt after 7 singles", 32'(cc0), 32'd7);

        // SECDED: double error and parity-bit-only error
        pkt1 = 12'h65A; e1 = '{data: 8'hDA, corr: 1'b0, unc: 1'b1, syn: 3'd3}; iv1 = 1'b1;
        step();
        pkt1 = 12'hD5A; e1 = '{data: 8'hBA, corr: 1'b1, unc: 1'b0, syn: 3'd0};
        step();
        drain(5);
        chk("secded uncorr_cnt", 32'(uc1), 32'd1);
        chk("secded corr_cnt", 32'(cc1), 32'd1);

        // Backpressure: only FIFO_DEPTH words fit
        out_ready = 1'b0;
        acc = 0;
        for (int i = 0; i < 6; i++) begin
            gen0($urandom_range(0, 1));
            iv0 = 1'b1;
            if (ir0) acc++;
            step();
        end
        chk("accepted under backpressure", 32'(acc), 32'd4);
        chk("in_ready when full", 32'(ir0), 32'd0);
        chk("head stable while stalled", 32'(ov0), 32'd1);
        drain(8);

        // Saturation and clear-with-event on the 2-bit counters
        clr_cnt = 1'b1;
        step();
        clr_cnt = 1'b0;
        mc0 = 0; mu0 = 0; mc1 = 0; mu1 = 0;
        chk("clr_cnt idle", 32'({cc0, uc0, cc1, uc1}), 32'd0);
        for (int i = 0; i < 5; i++) begin
            gen1(1);
            iv1 = 1'b1;
            step();
        end
        drain(5);
        chk("corr_cnt saturates", 32'(cc1), 32'd3);
        gen1(1);
        iv1 = 1'b1;
        step();
        iv1 = 1'b0;
        clr_cnt = 1'b1;
        step();
        clr_cnt = 1'b0;
        mc0 = 0; mu0 = 0; mc1 = 1; mu1 = 0;
        chk("clr with event corr_cnt", 32'(cc1), 32'd1);
        chk("clr with event uncorr_cnt", 32'(uc1), 32'd0);
        drain(4);

        // Randomised traffic on both variants against the scoreboard
        for (int i = 0; i < 300; i++) begin
            gen0($urandom_range(0, 1));
            gen1($urandom_range(0, 2));
            iv0 = 1'($urandom_range(0, 1));
            iv1 = 1'($urandom_range(0, 1));
            out_ready = ($urandom_range(0, 3) != 0);
            step();
        end
        drain(10);
        chk("random dut0 corr_cnt", 32'(cc0), 32'(mc0));
        chk("random dut0 uncorr_cnt", 32'(uc0), 32'(mu0));
        chk("random dut1 corr_cnt", 32'(cc1), 32'(mc1));
        chk("random dut1 uncorr_cnt", 32'(uc1), 32'(mu1));

        // Reset with three words buffered and one in S1
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            gen0(1);
            iv0 = 1'b1;
            step();
        end
        iv0 = 1'b0;
        rst_n = 1'b0;
        step();
        chk("mid reset out_valid", 32'(ov0), 32'd0);
        chk("mid reset in_ready", 32'(ir0), 32'd0);
        chk("mid reset counters", 32'({cc0, uc0}), 32'd0);
        q0.delete();
        rst_n = 1'b1;
        out_ready = 1'b1;
        for (int i = 0; i < 5; i++) step();
        chk("no stale word after reset", 32'(ov0), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
